// File: rtl/rr_arb_bin.sv
// Round-robin arbiter with a registered binary grant index and a valid/ready handshake.
// Define RR_ARB_LOCK_EN to add lock_i, which lets the current grantee keep the grant.
module rr_arb_bin #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic               gnt_valid_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  input  logic               gnt_ready_i
`ifdef RR_ARB_LOCK_EN
  ,
  input  logic               lock_i
`endif
);

  // state | meaning
  // IDLE  | no grant outstanding; arbitrate from ptr when any request is present
  // GRANT | gnt_idx_o is valid and held until accepted; re-arbitrate on accept

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_inc;
  logic [IDX_W-1:0]   base;
  logic [IDX_W-1:0]   win;
  logic               any_req;
  int                 k;

  // ptr wraps at NUM_REQ, not at 2^IDX_W, so non-power-of-two sizes stay in range
  always_comb begin
    ptr_inc = idx_q + 1'b1;
    if (idx_q == IDX_W'(NUM_REQ - 1))
      ptr_inc = '0;
    base = (state_q == GRANT) ? ptr_inc : ptr_q;
  end

  always_comb begin
    any_req = 1'b0;
    win     = '0;
    k       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(base) + i;
      if (k >= NUM_REQ)
        k = k - NUM_REQ;
      if (!any_req && req_i[k]) begin
        any_req = 1'b1;
        win     = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          idx_d   = win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (gnt_ready_i) begin
`ifdef RR_ARB_LOCK_EN
          if (lock_i && req_i[idx_q]) begin
            idx_d   = idx_q;
            state_d = GRANT;
          end else begin
            ptr_d = ptr_inc;
            if (any_req)
              idx_d = win;
            else
              state_d = IDLE;
          end
`else
          ptr_d = ptr_inc;
          if (any_req)
            idx_d = win;
          else
            state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_valid_o = (state_q == GRANT);
    gnt_idx_o   = idx_q;
  end

endmodule

// File: tb/tb_rr_arb_bin.sv
// Scoreboard bench for rr_arb_bin: a 16-requester and a 12-requester instance share clock and reset.
module tb_rr_arb_bin;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] req = '0;
  logic        ready = 1'b0;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [11:0] req12 = '0;
  logic        ready12 = 1'b0;
  logic        gnt_valid12;
  logic [3:0]  gnt_idx12;
  logic        lock = 1'b0;

  typedef struct {
    bit v;
    int idx;
  } exp_t;

  exp_t q0[$];
  exp_t q12[$];
  bit   mon_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rr_arb_bin #(.NUM_REQ(16)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .gnt_ready_i (ready)
`ifdef RR_ARB_LOCK_EN
    ,
    .lock_i      (lock)
`endif
  );

  rr_arb_bin #(.NUM_REQ(12)) u_dut12 (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req12),
    .gnt_valid_o (gnt_valid12),
    .gnt_idx_o   (gnt_idx12),
    .gnt_ready_i (ready12)
`ifdef RR_ARB_LOCK_EN
    ,
    .lock_i      (lock)
`endif
  );

  function automatic void check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (q0.size() > 0) begin
        exp_t e;
        e = q0.pop_front();
        check("valid16", int'(gnt_valid), int'(e.v));
        if (e.v)
          check("idx16", int'(gnt_idx), e.idx);
      end else begin
        check("spurious_valid16", int'(gnt_valid), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (q12.size() > 0) begin
        exp_t e;
        e = q12.pop_front();
        check("valid12", int'(gnt_valid12), int'(e.v));
        if (e.v) begin
          check("idx12", int'(gnt_idx12), e.idx);
          check("range12", int'(gnt_idx12 < 4'd12), 1);
        end
      end else begin
        check("spurious_valid12", int'(gnt_valid12), 0);
      end
    end
  end

  // Drive one cycle of stimulus; expectation describes outputs after the coming edge.
  task automatic cyc(input bit sel, input logic [15:0] r, input bit rdy, input bit v, input int idx);
    exp_t e;
    e.v   = v;
    e.idx = idx;
    if (!sel) begin
      req = r; ready = rdy; req12 = '0; ready12 = 1'b0;
    end else begin
      req12 = r[11:0]; ready12 = rdy; req = '0; ready = 1'b0;
    end
    @(posedge clk);
    if (!sel) q0.push_back(e);
    else      q12.push_back(e);
    #1;
  endtask

  // Assert reset between edges and confirm the outputs clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #1;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    req = '0; ready = 1'b0; req12 = '0; ready12 = 1'b0;
    #1;
    check("rst_valid16", int'(gnt_valid), 0);
    check("rst_idx16", int'(gnt_idx), 0);
    check("rst_valid12", int'(gnt_valid12), 0);
    check("rst_idx12", int'(gnt_idx12), 0);
    check("rst_q_empty", q0.size() + q12.size(), 0);
    q0.delete();
    q12.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, then reset again while a grant is outstanding
    do_reset();
    cyc(0, 16'h0004, 0, 1, 2);
    cyc(0, 16'h0004, 0, 1, 2);
    do_reset();
    cyc(0, 16'h0004, 0, 1, 2);
    cyc(0, 16'h0004, 1, 1, 2);
    cyc(0, 16'h0000, 1, 0, 0);

    // sole requester re-granted every cycle
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 16'h0001, 1, 1, 0);
    cyc(0, 16'h0000, 1, 0, 0);

    // everyone requesting: rotate through all and wrap
    do_reset();
    for (int i = 0; i < 18; i++) cyc(0, 16'hFFFF, 1, 1, i % 16);
    cyc(0, 16'h0000, 1, 0, 0);

    // backpressure holds the grant even after the request is withdrawn
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 16'h0110, 0, 1, 4);
    cyc(0, 16'h0100, 0, 1, 4);
    cyc(0, 16'h0100, 0, 1, 4);
    cyc(0, 16'h0100, 1, 1, 8);
    cyc(0, 16'h0000, 1, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0);
    @(negedge clk);
    #1;
    check("idle_idx_hold", int'(gnt_idx), 8);
    cyc(0, 16'h0110, 1, 1, 4);
    cyc(0, 16'h0110, 1, 1, 8);
    cyc(0, 16'h0000, 1, 0, 0);

    // NUM_REQ=12: pointer wraps at 11 -> 0, never reaching 12..15
    do_reset();
    cyc(1, 16'h0800, 0, 1, 11);
    cyc(1, 16'h0801, 1, 1, 0);
    cyc(1, 16'h0801, 1, 1, 11);
    cyc(1, 16'h0801, 1, 1, 0);
    cyc(1, 16'h0000, 1, 0, 0);
    do_reset();
    for (int i = 0; i < 14; i++) cyc(1, 16'h0FFF, 1, 1, i % 12);
    cyc(1, 16'h0000, 1, 0, 0);

`ifdef RR_ARB_LOCK_EN
    do_reset();
    lock = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 16'h0003, 1, 1, 0);
    lock = 1'b0;
    cyc(0, 16'h0003, 1, 1, 1);
    lock = 1'b1;
    cyc(0, 16'h0002, 1, 1, 1);
    cyc(0, 16'h0001, 1, 1, 0);
    lock = 1'b0;
    cyc(0, 16'h0000, 1, 0, 0);
`endif

    @(negedge clk);
    #1;
    check("final_q_empty", q0.size() + q12.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
